// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: exception / interrupt / eret sequencer at the commit boundary.
// Detects a commit-time event, pulses the CP0 wb_* or eret_flush strobe, holds
// pipe_flush for FLUSH_CYCLES cycles, then offers a redirect target to fetch
// over a valid/ready handshake.
// Optional feature: define CP0_EXC_INT_EN to compile in interrupt sampling.
module cp0_exc_ctrl #(
    parameter int unsigned FLUSH_CYCLES    = 2,
    parameter logic [31:0] EXC_VECTOR_BEV  = 32'hBFC00380,
    parameter logic [31:0] EXC_VECTOR_NORM = 32'h80000180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  logic [31:0] commit_pc,
    input  logic        commit_bd,
    input  logic        commit_ex,
    input  logic [4:0]  commit_excode,
    input  logic [31:0] commit_badvaddr,
    input  logic        commit_eret,
    input  logic        c0_status_bev,
    input  logic        c0_status_exl,
    input  logic        c0_status_ie,
    input  logic [7:0]  c0_status_im,
    input  logic [7:0]  c0_cause_ip,
    input  logic [31:0] c0_epc,
    output logic        wb_ex,
    output logic [4:0]  wb_excode,
    output logic        wb_bd,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_badvaddr,
    output logic        eret_flush,
    output logic        pipe_flush,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc
);

    localparam logic [3:0] CntLoad = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StFlush, StRedirect} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        int_pending_q;
    logic        wb_ex_q, eret_flush_q, wb_bd_q;
    logic [4:0]  wb_excode_q;
    logic [31:0] wb_pc_q, wb_badvaddr_q, redirect_pc_q;

    logic accept, exc_evt, eret_evt, any_evt;

`ifdef CP0_EXC_INT_EN
    // Interrupt request sampled every cycle; affects commits from the next cycle on
    always_ff @(posedge clk or posedge reset) begin
        if (reset) int_pending_q <= 1'b0;
        else       int_pending_q <= c0_status_ie & ~c0_status_exl &
                                    (|(c0_cause_ip & c0_status_im));
    end
`else
    logic unused_int;
    assign int_pending_q = 1'b0;
    assign unused_int    = ^{c0_status_ie, c0_status_exl, c0_status_im, c0_cause_ip};
`endif

    // Event decode; interrupt outranks commit_ex, which outranks eret
    always_comb begin
        accept   = commit_valid & (state_q == StIdle);
        exc_evt  = accept & (int_pending_q | commit_ex);
        eret_evt = accept & ~int_pending_q & ~commit_ex & commit_eret;
        any_evt  = exc_evt | eret_evt;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (any_evt)        state_d = StFlush;
            StFlush:    if (cnt_q == 4'd0)  state_d = StRedirect;
            StRedirect: if (redirect_ready) state_d = StIdle;
            default:                        state_d = StIdle;
        endcase
    end

    // Moore outputs decoded from state
    always_comb begin
        commit_ready   = (state_q == StIdle);
        pipe_flush     = (state_q == StFlush);
        redirect_valid = (state_q == StRedirect);
    end

    // Flush length counter, loaded at the event
    always_comb begin
        cnt_d = cnt_q;
        if (any_evt)                                   cnt_d = CntLoad;
        else if (state_q == StFlush && cnt_q != 4'd0)  cnt_d = cnt_q - 4'd1;
    end

    // Counter, strobes and held CP0 update / redirect values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= 4'd0;
            wb_ex_q       <= 1'b0;
            eret_flush_q  <= 1'b0;
            wb_excode_q   <= 5'd0;
            wb_bd_q       <= 1'b0;
            wb_pc_q       <= 32'd0;
            wb_badvaddr_q <= 32'd0;
            redirect_pc_q <= 32'd0;
        end else begin
            cnt_q        <= cnt_d;
            wb_ex_q      <= exc_evt;
            eret_flush_q <= eret_evt;
            if (exc_evt) begin
                wb_excode_q   <= int_pending_q ? 5'h00 : commit_excode;
                wb_bd_q       <= commit_bd;
                wb_pc_q       <= commit_pc;
                wb_badvaddr_q <= commit_badvaddr;
                redirect_pc_q <= c0_status_bev ? EXC_VECTOR_BEV : EXC_VECTOR_NORM;
            end else if (eret_flush_q) begin
                // EPC is only stable the cycle after the eret commits
                redirect_pc_q <= c0_epc;
            end
        end
    end

    assign wb_ex       = wb_ex_q;
    assign eret_flush  = eret_flush_q;
    assign wb_excode   = wb_excode_q;
    assign wb_bd       = wb_bd_q;
    assign wb_pc       = wb_pc_q;
    assign wb_badvaddr = wb_badvaddr_q;
    assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Randomized bench for cp0_exc_ctrl with a timeline-based reference model:
// each event is remembered by the cycle it happened in, and every output is
// predicted from the distance to that cycle.
module tb_cp0_exc_ctrl;

    localparam int unsigned F     = 2;
    localparam logic [31:0] VBEV  = 32'hBFC00380;
    localparam logic [31:0] VNORM = 32'h80000180;

    logic        clk = 1'b0;
    logic        reset;
    logic        commit_valid, commit_ready, commit_bd, commit_ex, commit_eret;
    logic [31:0] commit_pc, commit_badvaddr, c0_epc;
    logic [4:0]  commit_excode;
    logic        c0_status_bev, c0_status_exl, c0_status_ie;
    logic [7:0]  c0_status_im, c0_cause_ip;
    logic        wb_ex, wb_bd, eret_flush, pipe_flush, redirect_valid, redirect_ready;
    logic [4:0]  wb_excode;
    logic [31:0] wb_pc, wb_badvaddr, redirect_pc;

    cp0_exc_ctrl #(
        .FLUSH_CYCLES    (F),
        .EXC_VECTOR_BEV  (VBEV),
        .EXC_VECTOR_NORM (VNORM)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .commit_valid    (commit_valid),
        .commit_ready    (commit_ready),
        .commit_pc       (commit_pc),
        .commit_bd       (commit_bd),
        .commit_ex       (commit_ex),
        .commit_excode   (commit_excode),
        .commit_badvaddr (commit_badvaddr),
        .commit_eret     (commit_eret),
        .c0_status_bev   (c0_status_bev),
        .c0_status_exl   (c0_status_exl),
        .c0_status_ie    (c0_status_ie),
        .c0_status_im    (c0_status_im),
        .c0_cause_ip     (c0_cause_ip),
        .c0_epc          (c0_epc),
        .wb_ex           (wb_ex),
        .wb_excode       (wb_excode),
        .wb_bd           (wb_bd),
        .wb_pc           (wb_pc),
        .wb_badvaddr     (wb_badvaddr),
        .eret_flush      (eret_flush),
        .pipe_flush      (pipe_flush),
        .redirect_valid  (redirect_valid),
        .redirect_ready  (redirect_ready),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int          cyc;
    bit          busy;
    int          ev_cyc;
    bit          ev_exc;
    bit          int_m;
    logic [4:0]  m_excode;
    logic        m_bd;
    logic [31:0] m_pc, m_bva, m_rpc;

    task automatic model_reset();
        busy = 0; int_m = 0; ev_exc = 0; ev_cyc = 0;
        m_excode = 5'd0; m_bd = 1'b0; m_pc = 32'd0; m_bva = 32'd0; m_rpc = 32'd0;
    endtask

    task automatic check_outputs();
        int d;
        d = busy ? (cyc - ev_cyc) : 0;
        check_eq("commit_ready",   32'(commit_ready),   32'(!busy));
        check_eq("wb_ex",          32'(wb_ex),          32'(busy && d == 1 && ev_exc));
        check_eq("eret_flush",     32'(eret_flush),     32'(busy && d == 1 && !ev_exc));
        check_eq("pipe_flush",     32'(pipe_flush),     32'(busy && d >= 1 && d <= int'(F)));
        check_eq("redirect_valid", 32'(redirect_valid), 32'(busy && d >= int'(F) + 1));
        check_eq("wb_excode",      32'(wb_excode),      32'(m_excode));
        check_eq("wb_bd",          32'(wb_bd),          32'(m_bd));
        check_eq("wb_pc",          wb_pc,               m_pc);
        check_eq("wb_badvaddr",    wb_badvaddr,         m_bva);
        if (busy && d >= int'(F) + 1) check_eq("redirect_pc", redirect_pc, m_rpc);
    endtask

    task automatic drive_random();
        commit_valid    = $urandom_range(0, 1) == 1;
        commit_ex       = $urandom_range(0, 3) == 0;
        commit_eret     = $urandom_range(0, 3) == 0;
        commit_excode   = 5'($urandom);
        commit_pc       = $urandom;
        commit_bd       = $urandom_range(0, 1) == 1;
        commit_badvaddr = $urandom;
        c0_epc          = $urandom;
        c0_status_bev   = $urandom_range(0, 1) == 1;
        c0_status_ie    = $urandom_range(0, 1) == 1;
        c0_status_exl   = $urandom_range(0, 3) == 0;
        c0_status_im    = 8'($urandom);
        c0_cause_ip     = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00;
        redirect_ready  = $urandom_range(0, 2) == 0;
    endtask

    // Advance the model over the clock edge that ends cycle cyc
    task automatic model_step();
        int d;
        if (busy) begin
            d = cyc - ev_cyc;
            if (d == 1 && !ev_exc) m_rpc = c0_epc;
            if (d >= int'(F) + 1 && redirect_ready) busy = 0;
        end else if (commit_valid && (int_m || commit_ex || commit_eret)) begin
            busy   = 1;
            ev_cyc = cyc;
            ev_exc = int_m || commit_ex;
            if (ev_exc) begin
                m_excode = int_m ? 5'h00 : commit_excode;
                m_bd     = commit_bd;
                m_pc     = commit_pc;
                m_bva    = commit_badvaddr;
                m_rpc    = c0_status_bev ? VBEV : VNORM;
            end
        end
`ifdef CP0_EXC_INT_EN
        int_m = c0_status_ie && !c0_status_exl && ((c0_cause_ip & c0_status_im) != 8'h00);
`else
        int_m = 0;
`endif
    endtask

    initial begin
        reset = 1'b1;
        commit_valid = 0; commit_ex = 0; commit_eret = 0; commit_excode = 0;
        commit_pc = 0; commit_bd = 0; commit_badvaddr = 0; c0_epc = 0;
        c0_status_bev = 0; c0_status_ie = 0; c0_status_exl = 0;
        c0_status_im = 0; c0_cause_ip = 0; redirect_ready = 0;
        model_reset();
        cyc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            check_outputs();
            // Occasionally hit reset mid-sequence; it must abort immediately
            if (busy && $urandom_range(0, 30) == 0) begin
                #1 reset = 1'b1;
                #1;
                check_eq("rst_pipe_flush",     32'(pipe_flush),     32'd0);
                check_eq("rst_redirect_valid", 32'(redirect_valid), 32'd0);
                check_eq("rst_commit_ready",   32'(commit_ready),   32'd1);
                check_eq("rst_wb_pc",          wb_pc,               32'd0);
                check_eq("rst_redirect_pc",    redirect_pc,         32'd0);
                #1 reset = 1'b0;
                model_reset();
            end
            drive_random();
            model_step();
            cyc++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Exception and interrupt sequencer for the CP0 register block. It sits at the writeback/commit boundary and watches each committing instruction for an exception, an `eret` or a pending interrupt. It produces the one-cycle `wb_*` update strobes that the CP0 registers consume, then flushes the pipeline and hands the fetch stage a redirect target through a valid/ready handshake.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: number of cycles `pipe_flush` is held; legal range 1..15.
- `EXC_VECTOR_BEV`, default 32'hBFC00380: exception vector used when BEV=1.
- `EXC_VECTOR_NORM`, default 32'h80000180: exception vector used when BEV=0.

Ports:
- `clk`  in  1  Clock; one clock domain only.
- `reset`  in  1  Asynchronous, active-high reset.
- `commit_valid`  in  1  An instruction is presented for commit.
- `commit_ready`  out  1  The controller accepts a commit; equals 1 only in IDLE.
- `commit_pc`  in  32  PC of the committing instruction.
- `commit_bd`  in  1  The instruction is in a branch delay slot.
- `commit_ex`  in  1  The instruction raised a synchronous exception.
- `commit_excode`  in  5  Exception code for `commit_ex`.
- `commit_badvaddr`  in  32  Faulting address, meaningful for ADEL/ADES.
- `commit_eret`  in  1  The instruction is an `eret`.
- `c0_status_bev`, `c0_status_exl`, `c0_status_ie`  in  1 each  CP0 Status fields.
- `c0_status_im`  in  8  Interrupt mask.
- `c0_cause_ip`  in  8  Interrupt pending bits.
- `c0_epc`  in  32  EPC, used as the `eret` target.
- `wb_ex`  out  1  One-cycle exception strobe to CP0.
- `wb_excode`  out  5  Exception code written to CP0.
- `wb_bd`  out  1  Delay-slot flag written to CP0.
- `wb_pc`  out  32  Raw PC of the faulting instruction; CP0 applies the -4 for delay slots.
- `wb_badvaddr`  out  32  Faulting address written to CP0.
- `eret_flush`  out  1  One-cycle `eret` strobe to CP0.
- `pipe_flush`  out  1  Kills all younger pipeline stages.
- `redirect_valid`  out  1  A redirect target is available to fetch.
- `redirect_ready`  in  1  Fetch accepts the redirect.
- `redirect_pc`  out  32  Redirect target.

## Operation
- **Interrupt sampling:** `int_pending_q` is registered every cycle as `c0_status_ie & ~c0_status_exl & |(c0_cause_ip & c0_status_im)`.
- **Event detection:** an event is a handshake `commit_valid & commit_ready` that carries one of the following, in priority order:
  1. Interrupt, when `int_pending_q`=1: excode 5'h00. The faulting PC is `commit_pc` and the instruction is not retired.
  2. `commit_ex`: excode is `commit_excode`.
  3. `commit_eret`.
- A handshake with none of these is a normal retire. It causes no output and no state change.
- **State machine:**
  - IDLE: on an exception or interrupt, go to FLUSH and latch `wb_*`. On `eret`, go to FLUSH and latch `eret_flush`.
  - FLUSH: `pipe_flush`=1. A down-counter loaded with FLUSH_CYCLES-1 decrements each cycle; at 0, go to REDIRECT.
  - REDIRECT: `redirect_valid`=1 with `redirect_pc` held stable. On `redirect_ready`, go to IDLE.
- **Redirect target:**
  - Exception or interrupt: `EXC_VECTOR_BEV` if `c0_status_bev` else `EXC_VECTOR_NORM`, sampled at the event cycle.
  - `eret`: `c0_epc` sampled in the cycle after the event, which is when EPC is stable.
- **Output hold:** `wb_badvaddr` is loaded from `commit_badvaddr` on every exception event. The registered `wb_excode`, `wb_bd`, `wb_pc` and `wb_badvaddr` values hold until the next event.
- **Reset:** `reset` forces IDLE at any time, including mid-FLUSH or mid-REDIRECT. The redirect is abandoned. Reset values:
  - `commit_ready`=1.
  - `wb_ex`, `eret_flush`, `pipe_flush`, `redirect_valid` = 0.
  - `wb_excode`=0, `wb_bd`=0, `wb_pc`=0, `wb_badvaddr`=0, `redirect_pc`=0.

## Timing
- The event handshake occurs in cycle N.
- `wb_ex` or `eret_flush` is high in cycle N+1 only.
- `pipe_flush` is high in cycles N+1 through N+FLUSH_CYCLES.
- `redirect_valid` rises in cycle N+FLUSH_CYCLES+1 and holds until it is sampled together with `redirect_ready`.
- `commit_ready` is low from N+1 until the cycle after the redirect handshake.
- Minimum spacing between two events is FLUSH_CYCLES+2 cycles.
- Interrupt recognition latency: a change on ip/im/ie/exl affects commits from the following cycle on.
- `commit_ex` and `commit_eret` both set: the exception wins and `eret_flush` stays 0.
- If `redirect_ready` is already high when `redirect_valid` rises, the handshake completes that cycle.

## Configuration
- `CP0_EXC_INT_EN` defined: interrupt sampling and priority 1 are compiled in.
- `CP0_EXC_INT_EN` undefined: `int_pending_q` is tied to 0, the im/ip/ie inputs are unused, and only synchronous exceptions and `eret` are sequenced.

## Test plan
- **Synchronous exception:** `commit_ex`=1, excode 5'h04, pc 32'hBFC00100, badvaddr 32'h1, bev=1, FLUSH_CYCLES=2.
  - Expect `wb_ex` at N+1 with `wb_pc`=32'hBFC00100 and `wb_badvaddr`=1.
  - Expect `pipe_flush` at N+1..N+2, then `redirect_pc`=32'hBFC00380 at N+3.
- **`eret`:** `commit_eret`=1 with `c0_epc`=32'hBFC00200 → `eret_flush` one cycle, `redirect_pc`=32'hBFC00200, `wb_ex` stays 0.
- **Interrupt priority:** ie=1, exl=0, im=8'h80, ip=8'h80, commit with `commit_ex` (excode 5'h0c) → `wb_excode`=0. With exl=1 and a plain commit → no event. With the macro undefined → no event.
- **Simultaneous exception and `eret`:** `commit_ex` and `commit_eret` together → `wb_ex`=1, `eret_flush`=0.
- **Backpressure:** `redirect_ready` held low for 5 cycles → `redirect_valid` and `redirect_pc` stay stable and `commit_ready` stays 0; `commit_ready` returns to 1 the cycle after ready rises.
- **Reset mid-operation:** assert `reset` during FLUSH → `pipe_flush` and `redirect_valid` drop immediately. After release, `commit_ready`=1 and a new exception sequences normally.
